// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control sequencer: opcodes, classes, states,
// ALU-class encodings and the registered datapath control word.
package ctrl_pkg;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_BR0  = 4'b0100;
    localparam logic [3:0] OP_BR1  = 4'b0101;
    localparam logic [3:0] OP_BR2  = 4'b0110;
    localparam logic [3:0] OP_ALUI0 = 4'b1000;
    localparam logic [3:0] OP_ALUI1 = 4'b1001;
    localparam logic [3:0] OP_LD0  = 4'b1010;
    localparam logic [3:0] OP_ST0  = 4'b1011;
    localparam logic [3:0] OP_LD1  = 4'b1100;
    localparam logic [3:0] OP_ST1  = 4'b1101;
    localparam logic [3:0] OP_ALUR = 4'b1111;

    localparam logic [1:0] ALUOP_NONE  = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_ADDR  = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    typedef enum logic [2:0] {
        CL_ALUR, CL_ALUI, CL_LOAD, CL_STORE, CL_BR, CL_JMP, CL_HALT, CL_ILL
    } op_class_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    typedef struct packed {
        logic       r15;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-sequencer bus: instruction/memory handshake inputs, datapath strobes,
// selects and status outputs. slave = sequencer, master = driver of opcode/ready.
interface multicycle_control_if #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 2
) ();
    logic              start;
    logic [OPW-1:0]    opcode;
    logic              mem_ready;
    logic              imem_req;
    logic              ir_write;
    logic              pc_inc;
    logic              pc_write;
    logic              r15;
    logic              alu_src;
    logic              mem_to_reg;
    logic              branch;
    logic [ALUOPW-1:0] alu_op;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              busy;
    logic              halted;
    logic              error;
    logic [2:0]        state;

    modport master (
        output start, opcode, mem_ready,
        input  imem_req, ir_write, pc_inc, pc_write, r15, alu_src, mem_to_reg,
               branch, alu_op, mem_read, mem_write, reg_write, busy, halted,
               error, state
    );

    modport slave (
        input  start, opcode, mem_ready,
        output imem_req, ir_write, pc_inc, pc_write, r15, alu_src, mem_to_reg,
               branch, alu_op, mem_read, mem_write, reg_write, busy, halted,
               error, state
    );
endinterface

// File: rtl/multicycle_control_opcode_decoder.sv
// Combinational opcode decode into instruction class and datapath control word.
module opcode_decoder
    import ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode_i,
    output op_class_e      cls_o,
    output ctrl_word_t     cw_o,
    output logic           illegal_o
);
    always_comb begin
        cls_o = CL_ILL;
        cw_o  = '0;
        // Any set bit above [3:0] makes the opcode illegal regardless of the low nibble.
        if ((opcode_i >> 4) == '0) begin
            case (opcode_i[3:0])
                OP_ALUR:            begin cls_o = CL_ALUR;  cw_o = '{1'b1, 1'b0, 1'b1, 1'b0, ALUOP_LOGIC}; end
                OP_ALUI0, OP_ALUI1: begin cls_o = CL_ALUI;  cw_o = '{1'b0, 1'b1, 1'b0, 1'b0, ALUOP_LOGIC}; end
                OP_LD0, OP_LD1:     begin cls_o = CL_LOAD;  cw_o = '{1'b0, 1'b1, 1'b1, 1'b0, ALUOP_ADDR};  end
                OP_ST0, OP_ST1:     begin cls_o = CL_STORE; cw_o = '{1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADDR};  end
                OP_BR0, OP_BR1, OP_BR2:
                                    begin cls_o = CL_BR;    cw_o = '{1'b1, 1'b1, 1'b0, 1'b1, ALUOP_CMP};   end
                OP_JMP:             begin cls_o = CL_JMP;   cw_o = '{1'b0, 1'b1, 1'b0, 1'b0, ALUOP_NONE};  end
                OP_HALT:            cls_o = CL_HALT;
                default:            cls_o = CL_ILL;
            endcase
        end
        illegal_o = (cls_o == CL_ILL);
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bounded memory wait.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes to ERROR instead of NOP.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int ALUOPW   = 2,
    parameter int MAX_WAIT = 15
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.slave bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    state_e        state_q, state_d;
    op_class_e     cls_q, cls_d;
    ctrl_word_t    cw_q, cw_d;
    logic [WW-1:0] wcnt_q, wcnt_d;

    op_class_e     dec_cls;
    ctrl_word_t    dec_cw;
    logic          dec_ill;
    logic          timeout;

    opcode_decoder #(.OPW(OPW)) u_dec (
        .opcode_i  (bus.opcode),
        .cls_o     (dec_cls),
        .cw_o      (dec_cw),
        .illegal_o (dec_ill)
    );

    // This cycle would be the MAX_WAIT-th without ready; ready in it still wins.
    assign timeout = !bus.mem_ready && (wcnt_q == WW'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= CL_HALT;
            cw_q    <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cw_q    <= cw_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cw_d    = cw_q;
        wcnt_d  = '0;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timeout)   state_d = S_ERROR;
                else                wcnt_d  = wcnt_q + WW'(1);
            end
            S_DECODE: begin
                cls_d = dec_cls;
                cw_d  = dec_cw;
                if (dec_cls == CL_HALT) state_d = S_HALTED;
                else if (dec_ill) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_ERROR;
`else
                    state_d = S_FETCH;
`endif
                end else state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    CL_ALUR, CL_ALUI:  state_d = S_WB;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)  state_d = (cls_q == CL_LOAD) ? S_WB : S_FETCH;
                else if (timeout)   state_d = S_ERROR;
                else                wcnt_d  = wcnt_q + WW'(1);
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.ir_write   = (state_q == S_FETCH) && bus.mem_ready;
    assign bus.pc_inc     = (state_q == S_FETCH) && bus.mem_ready;
    assign bus.pc_write   = (state_q == S_EXEC) && (cls_q == CL_BR || cls_q == CL_JMP);
    assign bus.mem_read   = (state_q == S_MEM) && (cls_q == CL_LOAD);
    assign bus.mem_write  = (state_q == S_MEM) && (cls_q == CL_STORE);
    assign bus.reg_write  = (state_q == S_WB);
    assign bus.r15        = cw_q.r15;
    assign bus.alu_src    = cw_q.alu_src;
    assign bus.mem_to_reg = cw_q.mem_to_reg;
    assign bus.branch     = cw_q.branch;
    assign bus.alu_op     = ALUOPW'(cw_q.alu_op);
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_ERROR);
    assign bus.halted     = (state_q == S_HALTED);
    assign bus.error      = (state_q == S_ERROR);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle expected output
// vectors are queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.OPW(4), .ALUOPW(2)) bus ();
    multicycle_control #(.OPW(4), .ALUOPW(2), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [2:0] ST_I = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                           ST_M = 3'd4, ST_W = 3'd5, ST_H = 3'd6, ST_X = 3'd7;
    // strobes: {imem_req, ir_write, pc_inc, pc_write, mem_read, mem_write, reg_write}
    localparam logic [6:0] N = 7'b0000000, IM = 7'b1000000, FR = 7'b1110000,
                           PW = 7'b0001000, MR = 7'b0000100, MW = 7'b0000010,
                           RW = 7'b0000001;
    // selects: {r15, alu_src, mem_to_reg, branch, alu_op[1:0]}
    localparam logic [5:0] Z = 6'b000000, SALUR = 6'b101011, SALUI = 6'b010011,
                           SLD = 6'b011010, SST = 6'b010010, SBR = 6'b110101,
                           SJMP = 6'b010000;

    typedef struct {
        logic [18:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    wire [18:0] act = {bus.state, bus.imem_req, bus.ir_write, bus.pc_inc, bus.pc_write,
                       bus.mem_read, bus.mem_write, bus.reg_write, bus.r15, bus.alu_src,
                       bus.mem_to_reg, bus.branch, bus.alu_op, bus.busy, bus.halted, bus.error};

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic [3:0] op, input logic mr,
                        input logic [2:0] st, input logic [6:0] strb, input logic [5:0] sel,
                        input string nm);
        exp_t e;
        reset         = r;
        bus.start     = s;
        bus.opcode    = op;
        bus.mem_ready = mr;
        e.v  = {st, strb, sel, (st >= ST_F && st <= ST_W), (st == ST_H), (st == ST_X)};
        e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.opcode = 4'h0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 4'hF, 1, ST_I, N, Z, "reset_idle");
        // ALU-R, zero-wait
        step(0, 1, 4'hF, 1, ST_I, N, Z, "idle_start");
        step(0, 0, 4'hF, 1, ST_F, FR, Z, "alur_fetch");
        step(0, 0, 4'hF, 1, ST_D, N, Z, "alur_decode");
        step(0, 0, 4'hF, 1, ST_E, N, SALUR, "alur_exec");
        step(0, 0, 4'hF, 1, ST_W, RW, SALUR, "alur_wb");
        // LOAD with three wait cycles in MEM
        step(0, 0, 4'hC, 1, ST_F, FR, SALUR, "ld_fetch");
        step(0, 0, 4'hC, 0, ST_D, N, SALUR, "ld_decode");
        step(0, 0, 4'hC, 0, ST_E, N, SLD, "ld_exec");
        for (int i = 0; i < 3; i++) step(0, 0, 4'hC, 0, ST_M, MR, SLD, "ld_mem_wait");
        step(0, 0, 4'hC, 1, ST_M, MR, SLD, "ld_mem_rdy");
        step(0, 0, 4'hC, 1, ST_W, RW, SLD, "ld_wb");
        // branch then jump
        step(0, 0, 4'h5, 1, ST_F, FR, SLD, "br_fetch");
        step(0, 0, 4'h5, 1, ST_D, N, SLD, "br_decode");
        step(0, 0, 4'h5, 1, ST_E, PW, SBR, "br_exec");
        step(0, 0, 4'h1, 1, ST_F, FR, SBR, "jmp_fetch");
        step(0, 0, 4'h1, 1, ST_D, N, SBR, "jmp_decode");
        step(0, 0, 4'h1, 1, ST_E, PW, SJMP, "jmp_exec");
        // STORE interrupted by reset in MEM
        step(0, 0, 4'hD, 1, ST_F, FR, SJMP, "st_fetch");
        step(0, 0, 4'hD, 1, ST_D, N, SJMP, "st_decode");
        step(0, 0, 4'hD, 0, ST_E, N, SST, "st_exec");
        step(0, 0, 4'hD, 0, ST_M, MW, SST, "st_mem_wait");
        step(1, 0, 4'hD, 0, ST_M, MW, SST, "st_mem_rst");
        step(0, 0, 4'hD, 0, ST_I, N, Z, "after_rst");
        step(0, 0, 4'hD, 1, ST_I, N, Z, "idle_hold");
        // full STORE, ALU-I, then illegal
        step(0, 1, 4'hB, 1, ST_I, N, Z, "idle_start2");
        step(0, 0, 4'hB, 1, ST_F, FR, Z, "st2_fetch");
        step(0, 0, 4'hB, 1, ST_D, N, Z, "st2_decode");
        step(0, 0, 4'hB, 1, ST_E, N, SST, "st2_exec");
        step(0, 0, 4'hB, 1, ST_M, MW, SST, "st2_mem");
        step(0, 0, 4'h9, 1, ST_F, FR, SST, "alui_fetch");
        step(0, 0, 4'h9, 1, ST_D, N, SST, "alui_decode");
        step(0, 0, 4'h9, 1, ST_E, N, SALUI, "alui_exec");
        step(0, 0, 4'h9, 1, ST_W, RW, SALUI, "alui_wb");
        step(0, 0, 4'h3, 1, ST_F, FR, SALUI, "ill_fetch");
        step(0, 0, 4'h3, 1, ST_D, N, SALUI, "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(0, 1, 4'h3, 1, ST_X, N, Z, "ill_trap");
        step(0, 1, 4'h3, 1, ST_X, N, Z, "ill_err_sticky");
`else
        step(0, 0, 4'h0, 1, ST_F, FR, Z, "ill_nop_fetch");
        step(0, 0, 4'h0, 1, ST_D, N, Z, "halt_decode");
        step(0, 1, 4'h0, 1, ST_H, N, Z, "halted");
        step(0, 1, 4'h0, 1, ST_H, N, Z, "halt_sticky");
`endif
        // FETCH timeout after exactly 15 idle cycles
        do_reset();
        step(0, 1, 4'h0, 0, ST_I, N, Z, "to_start");
        for (int i = 0; i < 15; i++) step(0, 0, 4'h0, 0, ST_F, IM, Z, "to_wait");
        step(0, 1, 4'h0, 0, ST_X, N, Z, "to_error");
        step(0, 0, 4'h0, 1, ST_X, N, Z, "to_err_sticky");
        // ready on the 15th cycle wins over timeout
        do_reset();
        step(0, 1, 4'h0, 0, ST_I, N, Z, "rdy15_start");
        for (int i = 0; i < 14; i++) step(0, 0, 4'h0, 0, ST_F, IM, Z, "rdy15_wait");
        step(0, 0, 4'h0, 1, ST_F, FR, Z, "rdy15_fetch");
        step(0, 0, 4'h0, 0, ST_D, N, Z, "halt_decode2");
        step(0, 1, 4'h0, 1, ST_H, N, Z, "halted2");
        step(0, 1, 4'h0, 1, ST_H, N, Z, "halt_sticky2");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
